// File: rtl/slab_interval_reducer_pkg.sv
// Shared definitions for the slab interval reducer.
// FP word layout (29 bits): exn[28:27] sign[26] exp[25:15] frac[14:0].
// Exn codes: 00 zero, 01 normal, 10 infinity, 11 NaN.
package slab_interval_reducer_pkg;

  localparam int unsigned FP_MSB  = 28;
  localparam int unsigned EXN_HI  = 28;
  localparam int unsigned EXN_LO  = 27;
  localparam int unsigned SIGN    = 26;
  localparam int unsigned EXP_HI  = 25;
  localparam int unsigned EXP_LO  = 15;
  localparam int unsigned FRAC_HI = 14;
  localparam int unsigned FRAC_LO = 0;

  localparam logic [1:0] EXN_ZERO = 2'b00;
  localparam logic [1:0] EXN_NORM = 2'b01;
  localparam logic [1:0] EXN_INF  = 2'b10;
  localparam logic [1:0] EXN_NAN  = 2'b11;

  localparam logic [FP_MSB:0] FP_POS_ZERO = '0;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StResolve,
    StOut
  } state_e;

  function automatic logic fp_is_nan(input logic [FP_MSB:0] x);
    return x[EXN_HI:EXN_LO] == EXN_NAN;
  endfunction

endpackage

// File: rtl/slab_interval_reducer_fp_key_ge.sv
// Combinational a >= b on the 29-bit slab FP format.
// NaN on either side gives 0; +0 and -0 compare equal; infinities order beyond all normals.
// Ports:
//   a_i, b_i  operands
//   ge_o      1 when a >= b and neither operand is NaN
module slab_interval_reducer_fp_key_ge
  import slab_interval_reducer_pkg::*;
(
  input  logic [FP_MSB:0] a_i,
  input  logic [FP_MSB:0] b_i,
  output logic            ge_o
);

  // Magnitude key {exn[1], exp, frac}: exn[1] lifts infinity above every normal.
  // The sign then negates it, giving a total order on a plain signed integer.
  function automatic logic signed [27:0] fp_key(input logic [FP_MSB:0] x);
    logic signed [27:0] mag;
    mag = {1'b0, x[EXN_HI], x[EXP_HI:EXP_LO], x[FRAC_HI:FRAC_LO]};
    if (x[EXN_HI:EXN_LO] == EXN_ZERO) begin
      return '0;
    end
    return x[SIGN] ? -mag : mag;
  endfunction

  always_comb begin
    ge_o = !fp_is_nan(a_i) && !fp_is_nan(b_i) && (fp_key(a_i) >= fp_key(b_i));
  end

endmodule

// File: rtl/slab_interval_reducer.sv
// Folds per-axis slab (t_near, t_far) beats of one ray into tmin = max(t_near) and
// tmax = min(t_far), then resolves hit = (tmax >= tmin) && (tmax >= +0) and the entry
// distance max(tmin, +0). One ray in flight; results held until accepted.
// Optional feature: define SLAB_NAN_FLAG_EN to add out_nan_o (NaN seen on any beat).
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid_i / in_ready_o      axis beat handshake
//   in_t_near_i / in_t_far_i     slab entry/exit t for the current axis
//   out_valid_o / out_ready_i    result handshake; result held while out_ready_i is low
//   out_hit_o, out_t_entry_o     hit flag and entry distance (+0 on miss)
//   out_nan_o                    only with SLAB_NAN_FLAG_EN
module slab_interval_reducer
  import slab_interval_reducer_pkg::*;
#(
  parameter int unsigned WIDTH    = 28,
  parameter int unsigned NUM_AXES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH:0]   in_t_near_i,
  input  logic [WIDTH:0]   in_t_far_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_hit_o,
  output logic [WIDTH:0]   out_t_entry_o
`ifdef SLAB_NAN_FLAG_EN
  ,
  output logic             out_nan_o
`endif
);

  localparam int unsigned CntW = $clog2(NUM_AXES);
  localparam logic [CntW-1:0] LastAxis = CntW'(NUM_AXES - 1);

  state_e          state_q;
  logic [CntW-1:0] axis_cnt_q;
  logic [WIDTH:0]  tmin_q, tmax_q, t_entry_q;
  logic            nan_seen_q, in_ready_q, out_valid_q, out_hit_q;
`ifdef SLAB_NAN_FLAG_EN
  logic            out_nan_q;
`endif

  // Comparators are shared: while accumulating they fold the beat in; in RESOLVE the
  // first two are steered onto the +0 bounds checks.
  logic           resolving;
  logic [WIDTH:0] cmp_a_lhs, cmp_a_rhs, cmp_b_rhs;
  logic           ge_a, ge_b, ge_span;
  logic           beat_nan, hit_w;

  always_comb begin
    resolving = (state_q == StResolve);
    cmp_a_lhs = resolving ? tmin_q : in_t_near_i;
    cmp_a_rhs = resolving ? FP_POS_ZERO : tmin_q;
    cmp_b_rhs = resolving ? FP_POS_ZERO : in_t_far_i;
    beat_nan  = fp_is_nan(in_t_near_i) || fp_is_nan(in_t_far_i);
    hit_w     = !nan_seen_q && ge_span && ge_b;
  end

  // ge(t_near, tmin) / ge(tmin, +0)
  slab_interval_reducer_fp_key_ge u_ge_near (
    .a_i  (cmp_a_lhs),
    .b_i  (cmp_a_rhs),
    .ge_o (ge_a)
  );

  // ge(tmax, t_far) / ge(tmax, +0)
  slab_interval_reducer_fp_key_ge u_ge_far (
    .a_i  (tmax_q),
    .b_i  (cmp_b_rhs),
    .ge_o (ge_b)
  );

  // ge(tmax, tmin)
  slab_interval_reducer_fp_key_ge u_ge_span (
    .a_i  (tmax_q),
    .b_i  (tmin_q),
    .ge_o (ge_span)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      axis_cnt_q  <= '0;
      tmin_q      <= FP_POS_ZERO;
      tmax_q      <= FP_POS_ZERO;
      t_entry_q   <= FP_POS_ZERO;
      nan_seen_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_hit_q   <= 1'b0;
`ifdef SLAB_NAN_FLAG_EN
      out_nan_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            tmin_q     <= in_t_near_i;
            tmax_q     <= in_t_far_i;
            nan_seen_q <= beat_nan;
            axis_cnt_q <= CntW'(1);
            state_q    <= StAccum;
          end
        end
        StAccum: begin
          if (in_valid_i) begin
            if (ge_a) tmin_q <= in_t_near_i;
            if (ge_b) tmax_q <= in_t_far_i;
            nan_seen_q <= nan_seen_q | beat_nan;
            if (axis_cnt_q == LastAxis) begin
              in_ready_q <= 1'b0;
              state_q    <= StResolve;
            end else begin
              axis_cnt_q <= axis_cnt_q + CntW'(1);
            end
          end
        end
        StResolve: begin
          out_hit_q   <= hit_w;
          t_entry_q   <= (hit_w && ge_a) ? tmin_q : FP_POS_ZERO;
`ifdef SLAB_NAN_FLAG_EN
          out_nan_q   <= nan_seen_q;
`endif
          out_valid_q <= 1'b1;
          state_q     <= StOut;
        end
        StOut: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            axis_cnt_q  <= '0;
`ifdef SLAB_NAN_FLAG_EN
            out_nan_q   <= 1'b0;
`endif
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = out_valid_q;
  assign out_hit_o     = out_hit_q;
  assign out_t_entry_o = t_entry_q;
`ifdef SLAB_NAN_FLAG_EN
  assign out_nan_o     = out_nan_q;
`endif

endmodule

// File: tb/tb_slab_interval_reducer.sv
module tb_slab_interval_reducer;

  localparam int NA = 3;
  typedef logic [28:0] fp_t;
  typedef logic [NA-1:0][28:0] ray_t;

  typedef struct {
    ray_t near;
    ray_t far;
    logic hit;
    fp_t  entry;
    logic nan;
  } vec_t;

  localparam fp_t P1   = 29'h09FF8000;
  localparam fp_t P2   = 29'h0A000000;
  localparam fp_t P3   = 29'h0A008000;
  localparam fp_t M1   = 29'h0DFF8000;
  localparam fp_t M2   = 29'h0E000000;
  localparam fp_t M3   = 29'h0E008000;
  localparam fp_t PZ   = 29'h00000000;
  localparam fp_t MZ   = 29'h04000000;
  localparam fp_t PINF = 29'h10000000;
  localparam fp_t MINF = 29'h14000000;
  localparam fp_t QNAN = 29'h18000000;

  logic clk, rst;
  logic in_valid, in_ready, out_valid, out_ready, out_hit;
  fp_t  in_t_near, in_t_far, out_t_entry;
`ifdef SLAB_NAN_FLAG_EN
  logic out_nan;
`endif

  int n_vec = 0;
  int n_err = 0;

  slab_interval_reducer #(
    .WIDTH    (28),
    .NUM_AXES (NA)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_t_near_i   (in_t_near),
    .in_t_far_i    (in_t_far),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_hit_o     (out_hit),
    .out_t_entry_o (out_t_entry)
`ifdef SLAB_NAN_FLAG_EN
    ,
    .out_nan_o     (out_nan)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic ray_t mk(input fp_t a, input fp_t b, input fp_t c);
    return {c, b, a};
  endfunction

  // Value of a word as a real; infinities as huge reals (random exps stay small).
  function automatic real to_real(input fp_t x);
    real v;
    int  e;
    case (x[28:27])
      2'b00: return 0.0;
      2'b10: return x[26] ? -1.0e300 : 1.0e300;
      2'b11: return 0.0;
      default: begin
        v = 1.0 + real'(x[14:0]) / 32768.0;
        e = int'(x[25:15]) - 1023;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return x[26] ? -v : v;
      end
    endcase
  endfunction

  // Reference: interval intersection over all axes; ties on tmin keep the later beat.
  task automatic model(input ray_t near, input ray_t far, output logic hit, output fp_t entry,
                       output logic nan);
    real mn, mx;
    int  idx;
    nan = 1'b0;
    for (int i = 0; i < NA; i++)
      if (near[i][28:27] == 2'b11 || far[i][28:27] == 2'b11) nan = 1'b1;
    hit   = 1'b0;
    entry = '0;
    if (!nan) begin
      mn  = to_real(near[0]);
      idx = 0;
      mx  = to_real(far[0]);
      for (int i = 1; i < NA; i++) begin
        if (to_real(near[i]) >= mn) begin mn = to_real(near[i]); idx = i; end
        if (to_real(far[i]) < mx) mx = to_real(far[i]);
      end
      hit = (mx >= mn) && (mx >= 0.0);
      if (hit && mn >= 0.0) entry = near[idx];
    end
  endtask

  function automatic fp_t rand_fp();
    int unsigned r;
    fp_t x;
    r = $urandom_range(0, 31);
    if (r == 0) x = {2'b11, 27'($urandom)};
    else if (r <= 2) x = ($urandom_range(0, 1) == 1) ? PINF : MINF;
    else if (r <= 5) x = ($urandom_range(0, 1) == 1) ? MZ : PZ;
    else begin
      x[28:27] = 2'b01;
      x[26]    = ($urandom_range(0, 3) == 0);
      x[25:15] = 11'(1018 + $urandom_range(0, 10));
      x[14:0]  = 15'($urandom);
    end
    return x;
  endfunction

  task automatic run_ray(input ray_t near, input ray_t far, input logic e_hit, input fp_t e_entry,
                         input logic e_nan, input int gap_max, input int hold, input bit junk);
    int w;
    for (int i = 0; i < NA; i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      in_valid  = 1'b1;
      in_t_near = near[i];
      in_t_far  = far[i];
      w = 0;
      while (!in_ready && w < 20) begin @(negedge clk); w++; end
      check("beat_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
    check("lat_resolve_valid", 32'(out_valid), 32'd0);
    check("resolve_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("lat_out_valid", 32'(out_valid), 32'd1);
    w = 0;
    while (!out_valid && w < 8) begin @(negedge clk); w++; end
    check("out_hit", 32'(out_hit), 32'(e_hit));
    check("out_t_entry", 32'(out_t_entry), 32'(e_entry));
`ifdef SLAB_NAN_FLAG_EN
    check("out_nan", 32'(out_nan), 32'(e_nan));
`endif
    for (int k = 0; k < hold; k++) begin
      if (junk) begin
        in_valid  = 1'b1;
        in_t_near = rand_fp();
        in_t_far  = rand_fp();
      end
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_hit", 32'(out_hit), 32'(e_hit));
      check("hold_entry", 32'(out_t_entry), 32'(e_entry));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("post_ack_in_ready", 32'(in_ready), 32'd1);
    check("post_ack_valid", 32'(out_valid), 32'd0);
  endtask

  vec_t tbl[9];

  initial begin
    logic m_hit, m_nan;
    fp_t  m_entry;
    ray_t rn, rf;

    tbl[0] = '{mk(P1, P2, P1), mk(P3, P3, P2), 1'b1, P2, 1'b0};       // hit, grazing
    tbl[1] = '{mk(P1, P3, MINF), mk(P2, PINF, PINF), 1'b0, PZ, 1'b0}; // miss
    tbl[2] = '{mk(M1, M1, M1), mk(P1, P2, P3), 1'b1, PZ, 1'b0};       // origin inside
    tbl[3] = '{mk(M3, M3, M3), mk(M1, M1, M1), 1'b0, PZ, 1'b0};       // box behind
    tbl[4] = '{mk(P1, QNAN, P1), mk(P3, P3, P3), 1'b0, PZ, 1'b1};     // NaN near
    tbl[5] = '{mk(P1, P1, P1), mk(P3, P3, P3), 1'b1, P1, 1'b0};       // after NaN
    tbl[6] = '{mk(P1, P1, P1), mk(P3, QNAN, P3), 1'b0, PZ, 1'b1};     // NaN far
    tbl[7] = '{mk(M1, M1, M1), mk(MZ, P1, P1), 1'b1, PZ, 1'b0};       // tmax = -0
    tbl[8] = '{mk(MZ, M1, M2), mk(P1, P1, P1), 1'b1, MZ, 1'b0};       // tmin = -0 passes

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_t_near = '0;
    in_t_far = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_hit", 32'(out_hit), 32'd0);
    check("rst_t_entry", 32'(out_t_entry), 32'd0);
`ifdef SLAB_NAN_FLAG_EN
    check("rst_out_nan", 32'(out_nan), 32'd0);
`endif

    for (int i = 0; i < 9; i++)
      run_ray(tbl[i].near, tbl[i].far, tbl[i].hit, tbl[i].entry, tbl[i].nan, 0, 0, 1'b0);

    // Backpressure with junk beats offered while the result is held.
    run_ray(tbl[0].near, tbl[0].far, 1'b1, P2, 1'b0, 0, 5, 1'b1);

    // Reset in the middle of a ray discards the partial beats.
    in_valid = 1'b1; in_t_near = M3; in_t_far = M2;
    @(posedge clk); @(negedge clk);
    in_t_near = M3; in_t_far = M2;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_hit", 32'(out_hit), 32'd0);
    @(negedge clk);
    run_ray(mk(P1, P1, P1), mk(P3, P3, P3), 1'b1, P1, 1'b0, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NA; i++) begin
        rn[i] = rand_fp();
        rf[i] = rand_fp();
      end
      model(rn, rf, m_hit, m_entry, m_nan);
      run_ray(rn, rf, m_hit, m_entry, m_nan, 2, $urandom_range(0, 2), $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
